// File: rtl/prog_loader_pkg.sv
// Shared FSM encodings, frame header constant and baud divider helper for the program loader.
// Pure definitions: no latency, no flow control.
package prog_loader_pkg;

   typedef enum logic [2:0] {IDLE, CNT_L, CNT_H, DAT_L, DAT_H, WRITE, CHK, DONE} state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   localparam logic [7:0] HDR_BYTE = 8'hA5;

   function automatic int calc_div(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: byte_valid/frame_err pulse about DIV/2 + 9*DIV cycles after the start edge.
// No backpressure: data holds the last good byte until the next one lands.
module uart_rx_byte
   import prog_loader_pkg::*;
#(
   parameter int DIV = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam logic [15:0] HALF_M1 = 16'(DIV / 2 - 1);
   localparam logic [15:0] FULL_M1 = 16'(DIV - 1);

   rx_state_t   st;
   logic [2:0]  sync;
   logic [15:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        rx_s;
   logic        rx_prev;
   logic        tick;

   // sync[1] is the synchronized line, sync[2] its previous value for edge detection
   assign rx_s    = sync[1];
   assign rx_prev = sync[2];
   assign tick    = (st == RX_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st         <= RX_IDLE;
         sync       <= 3'b111;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         data       <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sync       <= {sync[1:0], rx};
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (st == RX_IDLE || tick) cnt <= '0;
         else                       cnt <= cnt + 16'd1;
         case (st)
            RX_IDLE:  if (rx_prev && !rx_s) st <= RX_START;
            RX_START: if (tick) begin
                         bit_idx <= '0;
                         st      <= rx_s ? RX_IDLE : RX_DATA;
                      end
            RX_DATA:  if (tick) begin
                         shreg   <= {rx_s, shreg[7:1]};
                         bit_idx <= bit_idx + 3'd1;
                         if (bit_idx == 3'd7) st <= RX_STOP;
                      end
            RX_STOP:  if (tick) begin
                         st <= RX_IDLE;
                         if (rx_s) begin
                            data       <= shreg;
                            byte_valid <= 1'b1;
                         end else begin
                            frame_err  <= 1'b1;
                         end
                      end
            default:  st <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads little-endian 16-bit words from a UART frame into program memory; strobe starts the cycle after the high byte, PROG_CHECKSUM_EN adds a checksum byte and CHK state.
// No backpressure on rx: a byte arriving during the 3-cycle write strobe is held and consumed afterwards.
module uart_prog_loader
   import prog_loader_pkg::*;
#(
   parameter int CLK_HZ = 50_000_000,
   parameter int BAUD   = 115200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [15:0] dout,
   output logic [15:0] padd,
   output logic        wren,
   output logic        wclk,
   output logic        done,
   output logic        err
);

   localparam int DIV = calc_div(CLK_HZ, BAUD);
`ifdef PROG_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   state_t      state, state_nx;
   logic [7:0]  rx_dat;
   logic        rx_vld, rx_ferr;
   logic        pend, pend_nx, byte_evt, finish;
   logic [1:0]  wph, wph_nx;
   logic [7:0]  cnt_l, cnt_l_nx;
   logic [15:0] remain, remain_nx, dout_nx, padd_nx;
   logic        done_nx, err_nx;

   uart_rx_byte #(.DIV(DIV)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data       (rx_dat),
      .byte_valid (rx_vld),
      .frame_err  (rx_ferr)
   );

   // a byte that lands mid-strobe is replayed from pend once WRITE finishes
   assign byte_evt = (state != WRITE) && (rx_vld || pend);
   assign wren     = (state == WRITE) && (wph != 2'd2);
   assign wclk     = (state == WRITE) && (wph == 2'd1);

`ifdef PROG_CHECKSUM_EN
   logic [7:0] sum;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                                     sum <= '0;
      else if (byte_evt && (state == IDLE || state == DONE))        sum <= '0;
      else if (byte_evt && state inside {CNT_L, CNT_H, DAT_L, DAT_H}) sum <= 8'(sum + rx_dat);
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         pend   <= 1'b0;
         wph    <= '0;
         cnt_l  <= '0;
         remain <= '0;
         dout   <= '0;
         padd   <= '0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= state_nx;
         pend   <= pend_nx;
         wph    <= wph_nx;
         cnt_l  <= cnt_l_nx;
         remain <= remain_nx;
         dout   <= dout_nx;
         padd   <= padd_nx;
         done   <= done_nx;
         err    <= err_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      pend_nx   = (state == WRITE) ? (pend || rx_vld) : 1'b0;
      wph_nx    = wph;
      cnt_l_nx  = cnt_l;
      remain_nx = remain;
      dout_nx   = dout;
      padd_nx   = padd;
      done_nx   = done;
      err_nx    = err;
      finish    = 1'b0;
      case (state)
         IDLE, DONE: if (byte_evt && rx_dat == HDR_BYTE) begin
                        done_nx  = 1'b0;
                        err_nx   = 1'b0;
                        padd_nx  = '0;
                        state_nx = CNT_L;
                     end
         CNT_L:      if (byte_evt) begin
                        cnt_l_nx = rx_dat;
                        state_nx = CNT_H;
                     end
         CNT_H:      if (byte_evt) begin
                        remain_nx = {rx_dat, cnt_l};
                        if ({rx_dat, cnt_l} == 16'd0) finish   = 1'b1;
                        else                          state_nx = DAT_L;
                     end
         DAT_L:      if (byte_evt) begin
                        dout_nx[7:0] = rx_dat;
                        state_nx     = DAT_H;
                     end
         DAT_H:      if (byte_evt) begin
                        dout_nx[15:8] = rx_dat;
                        wph_nx        = '0;
                        state_nx      = WRITE;
                     end
         WRITE: begin
            wph_nx = wph + 2'd1;
            if (wph == 2'd1) begin
               padd_nx   = padd + 16'd1;
               remain_nx = remain - 16'd1;
            end
            if (wph == 2'd2) begin
               wph_nx = '0;
               if (remain == 16'd0) finish   = 1'b1;
               else                 state_nx = DAT_L;
            end
         end
`ifdef PROG_CHECKSUM_EN
         CHK:        if (byte_evt) begin
                        if (8'(sum + rx_dat) == 8'd0) begin
                           state_nx = DONE;
                           done_nx  = 1'b1;
                        end else begin
                           state_nx = IDLE;
                           err_nx   = 1'b1;
                        end
                     end
`endif
         default:    state_nx = IDLE;
      endcase
      if (finish) begin
         if (CHK_EN) begin
            state_nx = CHK;
         end else begin
            state_nx = DONE;
            done_nx  = 1'b1;
         end
      end
      if (rx_ferr && state != IDLE && state != DONE) begin
         err_nx   = 1'b1;
         state_nx = IDLE;
         pend_nx  = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized frame-level bench for uart_prog_loader: expected writes and flags come from the frame contents.
// Works with or without PROG_CHECKSUM_EN.
module tb_uart_prog_loader;

   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 100_000;
   localparam int DIV    = CLK_HZ / BAUD;
`ifdef PROG_CHECKSUM_EN
   localparam bit HAS_CHK = 1'b1;
`else
   localparam bit HAS_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic [15:0] dout, padd;
   logic        wren, wclk, done, err;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
      int          len;
      bit          shape_ok;
   } wr_t;

   wr_t         wr_q[$];
   logic [15:0] cur_words[$];
   int          run = 0;
   int          wclk_cnt = 0;
   logic [15:0] cap_a, cap_d;
   bit          shape;

   uart_prog_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
      .clk  (clk),
      .rst  (rst),
      .rx   (rx),
      .dout (dout),
      .padd (padd),
      .wren (wren),
      .wclk (wclk),
      .done (done),
      .err  (err)
   );

   always #5 clk = ~clk;

   // record each write burst: address/data at its first cycle, length, and strobe shape
   always @(negedge clk) begin
      if (wclk) wclk_cnt++;
      if (wren) begin
         if (run == 0) begin
            cap_a = padd;
            cap_d = dout;
            shape = !wclk;
         end else if (run == 1) begin
            shape = shape && wclk && (padd == cap_a) && (dout == cap_d);
         end
         run++;
      end else if (run != 0) begin
         wr_q.push_back('{cap_a, cap_d, run, shape});
         run = 0;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx = stop_bit;
      repeat (DIV) @(negedge clk);
      rx = 1'b1;
      repeat (DIV) @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_dout"}, 32'(dout), 32'd0);
      check_val({tag, "_padd"}, 32'(padd), 32'd0);
      check_val({tag, "_wren"}, 32'(wren), 32'd0);
      check_val({tag, "_wclk"}, 32'(wclk), 32'd0);
      check_val({tag, "_done"}, 32'(done), 32'd0);
      check_val({tag, "_err"},  32'(err),  32'd0);
   endtask

   // ferr_at: index of the data byte sent with a low stop bit, -1 for none
   task automatic run_frame(input bit bad_chk, input int ferr_at, input int noise);
      logic [7:0] bytes[$];
      logic [7:0] s, b;
      int         n, exp_wr, last;
      bit         exp_done, exp_err;
      n = cur_words.size();
      for (int i = 0; i < noise; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h5A;
         send_byte(b, 1'b1);
      end
      wr_q.delete();
      bytes.push_back(8'hA5);
      bytes.push_back(8'(n));
      bytes.push_back(8'(n >> 8));
      foreach (cur_words[i]) begin
         bytes.push_back(cur_words[i][7:0]);
         bytes.push_back(cur_words[i][15:8]);
      end
      if (HAS_CHK) begin
         s = 8'd0;
         for (int i = 1; i < bytes.size(); i++) s = 8'(s + bytes[i]);
         s = 8'(8'd0 - s);
         if (bad_chk) s = 8'(s + 8'($urandom_range(1, 255)));
         bytes.push_back(s);
      end
      if (ferr_at >= 0) begin
         exp_wr   = ferr_at / 2;
         exp_done = 1'b0;
         exp_err  = 1'b1;
         last     = 3 + ferr_at;
      end else begin
         exp_wr   = n;
         exp_err  = HAS_CHK && bad_chk;
         exp_done = !exp_err;
         last     = bytes.size() - 1;
      end
      for (int i = 0; i <= last; i++) send_byte(bytes[i], !(ferr_at >= 0 && i == last));
      repeat (4 * DIV) @(negedge clk);
      check_val("n_writes", 32'(wr_q.size()), 32'(exp_wr));
      for (int i = 0; i < wr_q.size() && i < exp_wr; i++) begin
         check_val("wr_addr",  32'(wr_q[i].a), 32'(i));
         check_val("wr_data",  32'(wr_q[i].d), 32'(cur_words[i]));
         check_val("wr_len",   32'(wr_q[i].len), 32'd2);
         check_val("wr_shape", 32'(wr_q[i].shape_ok), 32'd1);
      end
      check_val("padd_end",  32'(padd), 32'(exp_wr));
      check_val("done",      32'(done), 32'(exp_done));
      check_val("err",       32'(err),  32'(exp_err));
      check_val("wren_idle", 32'(wren), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int         n, ferr, wc0;
      bit         bad, got;

      rst = 1'b0;
      rx  = 1'b1;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b1;
      repeat (2 * DIV) @(negedge clk);
      check_val("post_rst_done", 32'(done), 32'd0);
      check_val("post_rst_err",  32'(err),  32'd0);

      cur_words = '{16'h1234};
      run_frame(1'b0, -1, 0);

`ifdef PROG_CHECKSUM_EN
      cur_words = '{16'h1234};
      run_frame(1'b1, -1, 0);
`endif

      cur_words = '{16'h1111, 16'h2222, 16'h3333};
      run_frame(1'b0, 3, 0);
      cur_words = '{16'hBEEF};
      run_frame(1'b0, -1, 0);

      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      cur_words.delete();
      run_frame(1'b0, -1, 0);

      cur_words = '{16'($urandom), 16'($urandom), 16'($urandom)};
      run_frame(1'b0, -1, 1);

      // reset while the second word's high byte is on the line
      wr_q.delete();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'hDE, 1'b1);
      send_byte(8'hC0, 1'b1);
      send_byte(8'h5A, 1'b1);
      b  = 8'h5A;
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      rst = 1'b0;
      #1;
      check_outputs_zero("midword_rst");
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (30 * DIV) @(negedge clk);
      check_val("midword_n_writes", 32'(wr_q.size()), 32'd1);
      if (wr_q.size() > 0) check_val("midword_wr0", 32'(wr_q[0].d), 32'h0000C0DE);
      check_val("midword_done", 32'(done), 32'd0);

      // reset on the first cycle of a write strobe
      wr_q.delete();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h77, 1'b1);
      b  = 8'h66;
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx  = 1'b1;
      wc0 = wclk_cnt;
      got = 1'b0;
      for (int i = 0; i < 3 * DIV; i++) begin
         @(negedge clk);
         if (wren) begin
            got = 1'b1;
            break;
         end
      end
      rst = 1'b0;
      #1;
      check_val("midwrite_seen", 32'(got), 32'd1);
      check_outputs_zero("midwrite_rst");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20 * DIV) @(negedge clk);
      check_val("midwrite_no_wclk", 32'(wclk_cnt - wc0), 32'd0);

      for (int t = 0; t < 8; t++) begin
         n = int'($urandom_range(1, 4));
         cur_words.delete();
         for (int k = 0; k < n; k++) cur_words.push_back(16'($urandom));
         ferr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2 * n - 1)) : -1;
         bad  = ($urandom_range(0, 2) == 0);
         run_frame(bad, ferr, int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
